// File: rtl/bg_sprite_pkg.sv
// Background sprite ROM: default geometry, bitmap tables and field-width helpers.
package bg_sprite_pkg;

    // Geometry and population of the built-in bitmap table
    localparam int DEF_SPR_W   = 8;
    localparam int DEF_SPR_H   = 8;
    localparam int DEF_SPRITES = 2;
    localparam int DEF_FRAMES  = 2;

    // One sprite row; bit 0 is pixel x=0
    typedef logic [DEF_SPR_W-1:0] row_t;

    // Bitmap indexed [sprite][frame][row]
    localparam row_t BITMAP [DEF_SPRITES][DEF_FRAMES][DEF_SPR_H] = '{
        // sprite 0: cloud; frame 1 is frame 0 rotated right by one bit (drift)
        '{ '{8'h00, 8'h00, 8'hCC, 8'h1E, 8'h6B, 8'hC1, 8'hFF, 8'h66},
           '{8'h00, 8'h00, 8'h66, 8'h0F, 8'hB5, 8'hE0, 8'hFF, 8'h33} },
        // sprite 1: bird, wing-up then wing-down
        '{ '{8'h10, 8'h18, 8'h1C, 8'hFE, 8'h7F, 8'h0C, 8'h00, 8'h00},
           '{8'h00, 8'h00, 8'h0C, 8'hFE, 8'h7F, 8'h1C, 8'h18, 8'h10} }
    };

    // Width of an index field able to address n items (never narrower than 1)
    function automatic int fld_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Width of the x or y field of the pixel counter for a power-of-2 extent
    function automatic int coord_w(input int extent);
        return $clog2(extent);
    endfunction

endpackage

// File: rtl/bg_sprite_lut.sv
// Combinational pixel lookup into the constant bitmap table.
module bg_sprite_lut
    import bg_sprite_pkg::*;
#(
    parameter int SPR_W       = 8,
    parameter int SPR_H       = 8,
    parameter int NUM_SPRITES = 2,
    parameter int NUM_FRAMES  = 2,
    localparam int XW = coord_w(SPR_W),
    localparam int YW = coord_w(SPR_H),
    localparam int SW = fld_w(NUM_SPRITES),
    localparam int FW = fld_w(NUM_FRAMES)
) (
    input  logic [SW-1:0] sprite,
    input  logic [FW-1:0] frame,
    input  logic [YW-1:0] y,
    input  logic [XW-1:0] x,
    output logic          pixel
);

    // Mux over the table; anything outside the configured or stored range reads as background
    always_comb begin
        pixel = 1'b0;
        for (int s = 0; s < DEF_SPRITES; s++)
            for (int f = 0; f < DEF_FRAMES; f++)
                for (int r = 0; r < DEF_SPR_H; r++)
                    for (int b = 0; b < DEF_SPR_W; b++)
                        if (s < NUM_SPRITES && f < NUM_FRAMES &&
                            int'(sprite) == s && int'(frame) == f &&
                            int'(y) == r && int'(x) == b)
                            pixel = BITMAP[s][f][r][b];
    end

endmodule

// File: rtl/bg_sprite_rom.sv
// Animated background sprite ROM: mirrored address decode, 1-cycle registered read,
// frame-tick divider and animation frame counter.
module bg_sprite_rom
    import bg_sprite_pkg::*;
#(
    parameter int SPR_W       = 8,
    parameter int SPR_H       = 8,
    parameter int NUM_SPRITES = 2,
    parameter int NUM_FRAMES  = 2,
    parameter int FRAME_DIV   = 4,
    localparam int XW = coord_w(SPR_W),
    localparam int YW = coord_w(SPR_H),
    localparam int SW = fld_w(NUM_SPRITES),
    localparam int FW = fld_w(NUM_FRAMES),
    localparam int DW = fld_w(FRAME_DIV)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [XW+YW-1:0] i_rom_counter,
    input  logic [SW-1:0]    i_sprite_sel,
    input  logic             i_req,
    input  logic             i_mirror,
    input  logic             i_anim_en,
    input  logic             i_frame_tick,
    output logic             o_sprite_color,
    output logic             o_valid,
    output logic [FW-1:0]    o_frame
);

    logic [XW-1:0] x_raw;
    logic [XW-1:0] x_eff;
    logic [YW-1:0] y;
    logic          pixel;
    logic [DW-1:0] div_cnt;
    logic          tick_q;

    assign x_raw = i_rom_counter[XW-1:0];
    assign y     = i_rom_counter[XW+YW-1:XW];
    // SPR_W is a power of 2, so SPR_W-1-x is just the bitwise complement
    assign x_eff = i_mirror ? ~x_raw : x_raw;
    assign tick_q = i_frame_tick & i_anim_en;

    bg_sprite_lut #(
        .SPR_W       (SPR_W),
        .SPR_H       (SPR_H),
        .NUM_SPRITES (NUM_SPRITES),
        .NUM_FRAMES  (NUM_FRAMES)
    ) u_lut (
        .sprite (i_sprite_sel),
        .frame  (o_frame),
        .y      (y),
        .x      (x_eff),
        .pixel  (pixel)
    );

    // Read pipeline: capture the pixel on a request, valid follows the request by one cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_sprite_color <= 1'b0;
            o_valid        <= 1'b0;
        end else begin
            o_valid <= i_req;
            if (i_req)
                o_sprite_color <= pixel;
        end
    end

    // Tick divider and frame counter; both frozen while animation is disabled
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt <= '0;
            o_frame <= '0;
        end else if (tick_q) begin
            if (div_cnt == DW'(FRAME_DIV - 1)) begin
                div_cnt <= '0;
                o_frame <= (o_frame == FW'(NUM_FRAMES - 1)) ? '0 : o_frame + 1'b1;
            end else begin
                div_cnt <= div_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_bg_sprite_rom.sv
// Scoreboard bench for bg_sprite_rom: driver queues expected pixels, monitor checks on o_valid.
module tb_bg_sprite_rom;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] i_rom_counter;
    logic       i_sprite_sel;
    logic [1:0] i_sprite_sel2;
    logic       i_req, i_mirror, i_anim_en, i_frame_tick;
    logic       o_sprite_color, o_valid;
    logic       o_frame;
    logic       o_sprite_color2, o_valid2;
    logic [0:0] o_frame2;

    int compared = 0;
    int mismatched = 0;
    bit exp_q[$];

    always #5 clk = ~clk;

    bg_sprite_rom dut (
        .clk(clk), .rst(rst), .i_rom_counter(i_rom_counter), .i_sprite_sel(i_sprite_sel),
        .i_req(i_req), .i_mirror(i_mirror), .i_anim_en(i_anim_en), .i_frame_tick(i_frame_tick),
        .o_sprite_color(o_sprite_color), .o_valid(o_valid), .o_frame(o_frame)
    );

    // Second instance with a 2-bit select so an out-of-range sprite can be addressed
    bg_sprite_rom #(.NUM_SPRITES(3)) dut_oor (
        .clk(clk), .rst(rst), .i_rom_counter(i_rom_counter), .i_sprite_sel(i_sprite_sel2),
        .i_req(i_req), .i_mirror(i_mirror), .i_anim_en(i_anim_en), .i_frame_tick(i_frame_tick),
        .o_sprite_color(o_sprite_color2), .o_valid(o_valid2), .o_frame(o_frame2)
    );

    task automatic chk(input string nm, input int act, input int exp);
        compared++;
        if (act != exp) begin
            mismatched++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Set inputs for the coming edge and queue the expected pixel if this is a request
    task automatic drive(input bit r, input int cnt, input bit mir, input bit sel,
                         input int sel2, input bit tk, input bit en, input bit exp);
        i_req         = r;
        i_rom_counter = 6'(cnt);
        i_mirror      = mir;
        i_sprite_sel  = sel;
        i_sprite_sel2 = 2'(sel2);
        i_frame_tick  = tk;
        i_anim_en     = en;
        if (r) exp_q.push_back(exp);
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 1, 0);
    endtask

    task automatic tick(input bit en);
        drive(0, 0, 0, 0, 0, 1, en, 0);
    endtask

    // Monitor: every valid output consumes the oldest expected pixel
    always @(negedge clk) begin
        if (!rst && o_valid) begin
            if (exp_q.size() == 0) begin
                compared++;
                mismatched++;
                $display("FAIL unexpected_valid: got valid with empty queue, color %0d", o_sprite_color);
            end else begin
                chk("pixel", int'(o_sprite_color), int'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        idle();
        #23;
        chk("reset_valid", int'(o_valid), 0);
        chk("reset_color", int'(o_sprite_color), 0);
        chk("reset_frame", int'(o_frame), 0);
        @(negedge clk); rst = 1'b0;

        // Basic reads, sprite 0 frame 0
        @(negedge clk); drive(1, 18, 0, 0, 0, 0, 1, 1);
        @(negedge clk); drive(1, 16, 0, 0, 0, 0, 1, 0);
        @(negedge clk); drive(1, 55, 0, 0, 0, 0, 1, 1);
        @(negedge clk); idle();
        @(negedge clk);
        chk("idle_valid", int'(o_valid), 0);
        chk("idle_color_held", int'(o_sprite_color), 1);
        // Mirrored reads
        drive(1, 16, 1, 0, 0, 0, 1, 1);
        @(negedge clk); drive(1, 26, 1, 0, 0, 0, 1, 0);
        @(negedge clk); idle();

        // Divider: three ticks leave frame 0, the fourth advances it
        for (int i = 0; i < 3; i++) begin @(negedge clk); tick(1); end
        @(negedge clk); chk("frame_before_div", int'(o_frame), 0); tick(1);
        @(negedge clk); chk("frame_advance", int'(o_frame), 1);
        tick(1);
        @(negedge clk); tick(1);
        // Disabled ticks must neither advance nor clear the divider (count now 2)
        for (int i = 0; i < 5; i++) begin @(negedge clk); tick(0); end
        @(negedge clk); chk("frame_frozen", int'(o_frame), 1); tick(1);
        @(negedge clk); chk("frame_div_kept", int'(o_frame), 1); tick(1);
        @(negedge clk); chk("frame_wrap", int'(o_frame), 0);

        // Three ticks, then the completing tick collides with a request (old frame 0 -> 0)
        tick(1);
        @(negedge clk); tick(1);
        @(negedge clk); tick(1);
        @(negedge clk); drive(1, 17, 0, 0, 0, 1, 1, 0);
        @(negedge clk); chk("frame_after_collide", int'(o_frame), 1);
        drive(1, 17, 0, 0, 0, 0, 1, 1);      // frame 1 row 0x66, x1 -> 1
        @(negedge clk); drive(1, 16, 1, 0, 0, 0, 1, 0);  // mirrored x7 of 0x66 -> 0
        @(negedge clk); drive(1, 4, 0, 1, 0, 0, 1, 0);   // bird frame 1 row0 0x00
        @(negedge clk); drive(1, 28, 0, 1, 0, 0, 1, 1);  // bird row3 0xFE bit4

        // Out-of-range sprite on the 3-sprite instance
        @(negedge clk); drive(1, 18, 0, 0, 0, 0, 1, 1);
        @(negedge clk);
        chk("oor_inrange_color", int'(o_sprite_color2), 1);
        chk("oor_frame", int'(o_frame2), 1);
        drive(1, 18, 0, 0, 3, 0, 1, 1);
        @(negedge clk);
        chk("oor_color", int'(o_sprite_color2), 0);
        chk("oor_valid", int'(o_valid2), 1);

        // Async reset between edges during continuous requests
        drive(1, 18, 0, 0, 0, 0, 1, 1);
        @(negedge clk); drive(1, 55, 0, 0, 0, 0, 1, 1);
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        chk("async_valid", int'(o_valid), 0);
        chk("async_color", int'(o_sprite_color), 0);
        chk("async_frame", int'(o_frame), 0);
        exp_q.delete();
        idle();
        @(negedge clk); rst = 1'b0;
        @(negedge clk);
        chk("post_rst_valid", int'(o_valid), 0);
        drive(1, 55, 0, 0, 0, 0, 1, 1);
        @(negedge clk); idle();
        @(negedge clk);
        @(negedge clk);
        chk("queue_drained", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
